alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, registered successor of the 6-bit combinational ALU: W-bit operands, valid/ready
//  handshake on input and output, registered flags, plus iterative multiply and barrel shift/rotate ops.
//  Sits between the operand register file and writeback; one operation in flight at a time.
// PARAMETERS
//  W  8  operand/result width; power of two, 4..32 (LW = $clog2(W))
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   reset, synchronous, active-high
//  in_valid   in   1   operation request
//  in_ready   out  1   block can accept a request this cycle
//  mode       in   2   00 arith, 01 logic, 10 mul/shift, 11 reserved
//  op         in   3   operation select within mode
//  a, b       in   W   operands (unsigned)
//  out_valid  out  1   result/flags valid
//  out_ready  in   1   consumer takes result this cycle
//  result     out  W   registered result
//  overflow   out  1   registered unsigned overflow/borrow flag
//  zero       out  1   result == 0 (derived from registered result)
//  illegal    out  1   registered: reserved opcode was executed
// BEHAVIOUR
//  Reset: state IDLE, out_valid=0, result=0, overflow=0, illegal=0, zero=1; mid-op reset aborts, no output.
//  FSM IDLE/MUL/DONE. in_ready = (IDLE) | (DONE & out_ready). Accept = in_valid & in_ready;
//   mode/op/a/b latched at accept, later input changes ignored.
//  Accept of single-cycle op -> DONE next cycle (out_valid 1 cycle after accept edge).
//  Accept of MUL -> MUL for exactly W cycles (shift-add, 1 bit/cycle, LW+1-bit counter) -> DONE;
//   out_valid W+1 cycles after accept edge.
//  DONE: out_valid=1, result/flags stable until out_ready; then IDLE, or directly new op if accepted same cycle.
//  Arith (mode 00), overflow unsigned, result mod 2^W:
//   000 a+b   ov=carry-out | 001 a-b  ov=(a<b) | 010 a+~b ov=carry-out | 011 a-~b ov=(a<~b)
//   100 a+1   ov=(a=all1)  | 101 a-1  ov=(a=0) | 110 b+1  ov=(b=all1) | 111 b-1  ov=(b=0)
//  Logic (mode 01), ov=0: 000 a&b, 001 ~a, 010 ~b, 011 a|b, 100 a^b, 101 ~(a&b), 110 a, 111 b.
//  Mode 10: 000 MUL: result=low W bits of a*b, ov=(high W bits!=0);
//   001 SHL a<<b[LW-1:0]; 010 SHR logical; 011 ROL a by b[LW-1:0]; shifts single-cycle, ov=0.
//  Reserved (mode 10 op 1xx, mode 11 any): single-cycle, result=0, ov=0, illegal=1 (zero=1).
//  illegal=0 for every legal op. Flags update only when result updates.
// TESTING (W=8 unless noted)
//  ADD a=200,b=100 -> 1 cycle later out_valid, result=44, overflow=1, zero=0
//  SUB a=5,b=5 -> result=0, zero=1, ov=0; DEC a=0 -> result=255, ov=1; NAND 0xFF,0xFF -> 0, zero=1
//  MUL 15*17 -> out_valid 9 cycles after accept, result=255, ov=0; MUL 16*16 -> result=0, ov=1, zero=1
//  out_ready low 5 cycles in DONE -> result/flags stable, in_ready=0; then out_ready=in_valid=1 same cycle -> back-to-back accept, next result 1 cycle later
//  rst=1 on 4th MUL cycle -> next edge out_valid=0, in_ready=1, result=0, zero=1, no stale output after release
//  ROL 0x81 by 1 -> 0x03; SHR 0x80 by 7 -> 0x01; mode 11 op 000 -> result=0, illegal=1; W=16 ADD 0xFFFF+1 -> 0, ov=1

Source files
------------

// File: rtl/alu_seq.sv
// Registered W-bit ALU with valid/ready handshakes, one operation in flight.
// Arith/logic/shift ops finish in one cycle; MUL iterates shift-add for W cycles.
module alu_seq #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   mode,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         zero,
    output logic         illegal
);

    localparam int unsigned LW = $clog2(W);
    localparam int unsigned CW = LW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           accept;
    logic           is_mul;
    logic           mul_last;

    logic [W-1:0]   alu_res;
    logic           alu_ov;
    logic           alu_ill;
    logic [LW-1:0]  shamt;
    logic [W:0]     sum_ab;
    logic [W:0]     sum_anb;
    logic [W-1:0]   rol_res;

    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [2*W-1:0] acc_step;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   result_q, result_d;
    logic           ov_q, ov_d;
    logic           ill_q, ill_d;

    assign accept   = in_valid & in_ready;
    assign is_mul   = (mode == 2'b10) && (op == 3'b000);
    assign mul_last = (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE can hand straight over to a newly accepted op
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = is_mul ? S_MUL : S_DONE;
            S_MUL:  if (mul_last) state_d = S_DONE;
            S_DONE: begin
                if (accept) begin
                    state_d = is_mul ? S_MUL : S_DONE;
                end else if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign shamt   = b[LW-1:0];
    assign sum_ab  = {1'b0, a} + {1'b0, b};
    assign sum_anb = {1'b0, a} + {1'b0, ~b};
    // A shift by exactly W (shamt == 0) yields zero, leaving a unrotated
    assign rol_res = (a << shamt) | (a >> (CW'(W) - {1'b0, shamt}));

    // Single-cycle operations
    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        alu_ill = 1'b0;
        case (mode)
            2'b00: begin
                case (op)
                    3'b000: begin alu_res = sum_ab[W-1:0];  alu_ov = sum_ab[W];  end
                    3'b001: begin alu_res = a - b;          alu_ov = (a < b);    end
                    3'b010: begin alu_res = sum_anb[W-1:0]; alu_ov = sum_anb[W]; end
                    3'b011: begin alu_res = a - ~b;         alu_ov = (a < ~b);   end
                    3'b100: begin alu_res = a + W'(1);      alu_ov = &a;         end
                    3'b101: begin alu_res = a - W'(1);      alu_ov = (a == '0);  end
                    3'b110: begin alu_res = b + W'(1);      alu_ov = &b;         end
                    default: begin alu_res = b - W'(1);     alu_ov = (b == '0);  end
                endcase
            end
            2'b01: begin
                case (op)
                    3'b000:  alu_res = a & b;
                    3'b001:  alu_res = ~a;
                    3'b010:  alu_res = ~b;
                    3'b011:  alu_res = a | b;
                    3'b100:  alu_res = a ^ b;
                    3'b101:  alu_res = ~(a & b);
                    3'b110:  alu_res = a;
                    default: alu_res = b;
                endcase
            end
            2'b10: begin
                case (op)
                    3'b000:  ;
                    3'b001:  alu_res = a << shamt;
                    3'b010:  alu_res = a >> shamt;
                    3'b011:  alu_res = rol_res;
                    default: alu_ill = 1'b1;
                endcase
            end
            default: alu_ill = 1'b1;
        endcase
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Datapath next-state: latch at accept, step the multiplier while in MUL
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ov_d     = ov_q;
        ill_d    = ill_q;
        if (accept) begin
            if (is_mul) begin
                acc_d    = '0;
                mcand_d  = {{W{1'b0}}, a};
                mplier_d = b;
                cnt_d    = '0;
            end else begin
                result_d = alu_res;
                ov_d     = alu_ov;
                ill_d    = alu_ill;
            end
        end else if (state_q == S_MUL) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (mul_last) begin
                result_d = acc_step[W-1:0];
                ov_d     = |acc_step[2*W-1:W];
                ill_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ov_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ov_q     <= ov_d;
            ill_q    <= ill_d;
        end
    end

    assign result   = result_q;
    assign overflow = ov_q;
    assign illegal  = ill_q;
    assign zero     = (result_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors queue expectations, a monitor
// checks each result as the consumer takes it, including handshake latency.
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [1:0] mode;
    logic [2:0] op;
    logic [7:0] a, b, result;
    logic       overflow, zero, illegal;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [1:0]  w_mode;
    logic [2:0]  w_op;
    logic [15:0] w_a, w_b, w_result;
    logic        w_overflow, w_zero, w_illegal;

    alu_seq #(.W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .op(op), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .overflow(overflow),
        .zero(zero), .illegal(illegal)
    );

    alu_seq #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .mode(w_mode), .op(w_op), .a(w_a), .b(w_b), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .result(w_result), .overflow(w_overflow),
        .zero(w_zero), .illegal(w_illegal)
    );

    typedef struct {
        string      name;
        logic [7:0] res;
        logic       ov;
        logic       ill;
        int         lat;
        int         issue_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   started = 1'b0;
    int   start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record when a result first appears, check it when it is taken
    always begin
        exp_t e;
        int   lat;
        @(negedge clk);
        #1;
        if (rst) begin
            started = 1'b0;
        end else if (out_valid) begin
            if (!started) begin
                started   = 1'b1;
                start_cyc = cyc;
            end
            if (out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output result=%0d ov=%0b ill=%0b", result, overflow, illegal);
                end else begin
                    e   = sb.pop_front();
                    lat = start_cyc - e.issue_cyc;
                    if (result !== e.res || overflow !== e.ov || illegal !== e.ill ||
                        zero !== (e.res == 8'd0) || lat != e.lat) begin
                        n_bad++;
                        $display("FAIL %s res/ov/zero/ill/lat got %0d/%0b/%0b/%0b/%0d need %0d/%0b/%0b/%0b/%0d",
                                 e.name, result, overflow, zero, illegal, lat,
                                 e.res, e.ov, (e.res == 8'd0), e.ill, e.lat);
                    end
                end
                started = 1'b0;
            end
        end
    end

    // Present an op at the current negedge; queue its expectation once it will be accepted
    task automatic issue(input string nm, input logic [1:0] m, input logic [2:0] o,
                         input logic [7:0] av, input logic [7:0] bv, input logic [7:0] er,
                         input logic eov, input logic eil, input int lat);
        exp_t e;
        int   n;
        mode = m; op = o; a = av; b = bv; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s accept_timeout in_ready=%0b need 1", nm, in_ready);
            in_valid = 1'b0;
            return;
        end
        e.name = nm; e.res = er; e.ov = eov; e.ill = eil; e.lat = lat; e.issue_cyc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        // Scramble operands after accept: the DUT must hold its latched copy
        in_valid = 1'b0; a = ~av; b = ~bv; mode = 2'b11; op = 3'b111;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s result_timeout pending=%0d need 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input string nm, input logic [1:0] m, input logic [2:0] o,
                       input logic [7:0] av, input logic [7:0] bv, input logic [7:0] er,
                       input logic eov, input logic eil, input int lat);
        @(negedge clk);
        issue(nm, m, o, av, bv, er, eov, eil, lat);
        drain(nm);
    endtask

    initial begin
        int n;
        bit seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = '0; op = '0; a = '0; b = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b1; w_mode = '0; w_op = '0; w_a = '0; w_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 8'd0 || zero !== 1'b1 ||
            overflow !== 1'b0 || illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state ov/ir/res/z/ovf/ill got %0b/%0b/%0d/%0b/%0b/%0b need 0/1/0/1/0/0",
                     out_valid, in_ready, result, zero, overflow, illegal);
        end
        rst = 1'b0;

        run("add",      2'b00, 3'b000, 8'd200,  8'd100,  8'd44,   1'b1, 1'b0, 1);
        run("sub_eq",   2'b00, 3'b001, 8'd5,    8'd5,    8'd0,    1'b0, 1'b0, 1);
        run("sub_brw",  2'b00, 3'b001, 8'd3,    8'd5,    8'd254,  1'b1, 1'b0, 1);
        run("a_pl_nb",  2'b00, 3'b010, 8'd10,   8'd3,    8'd6,    1'b1, 1'b0, 1);
        run("a_mi_nb",  2'b00, 3'b011, 8'd10,   8'd3,    8'd14,   1'b1, 1'b0, 1);
        run("inc_a",    2'b00, 3'b100, 8'hFF,   8'd0,    8'd0,    1'b1, 1'b0, 1);
        run("dec_a",    2'b00, 3'b101, 8'd0,    8'd9,    8'd255,  1'b1, 1'b0, 1);
        run("inc_b",    2'b00, 3'b110, 8'd0,    8'd7,    8'd8,    1'b0, 1'b0, 1);
        run("dec_b",    2'b00, 3'b111, 8'd4,    8'd0,    8'd255,  1'b1, 1'b0, 1);
        run("and",      2'b01, 3'b000, 8'hF0,   8'h3C,   8'h30,   1'b0, 1'b0, 1);
        run("not_a",    2'b01, 3'b001, 8'h0F,   8'h00,   8'hF0,   1'b0, 1'b0, 1);
        run("not_b",    2'b01, 3'b010, 8'h00,   8'h55,   8'hAA,   1'b0, 1'b0, 1);
        run("or",       2'b01, 3'b011, 8'hF0,   8'h0F,   8'hFF,   1'b0, 1'b0, 1);
        run("xor",      2'b01, 3'b100, 8'hFF,   8'h0F,   8'hF0,   1'b0, 1'b0, 1);
        run("nand",     2'b01, 3'b101, 8'hFF,   8'hFF,   8'h00,   1'b0, 1'b0, 1);
        run("pass_a",   2'b01, 3'b110, 8'h5A,   8'h00,   8'h5A,   1'b0, 1'b0, 1);
        run("pass_b",   2'b01, 3'b111, 8'h00,   8'hA5,   8'hA5,   1'b0, 1'b0, 1);
        run("mul_15_17",2'b10, 3'b000, 8'd15,   8'd17,   8'd255,  1'b0, 1'b0, 9);
        run("mul_16_16",2'b10, 3'b000, 8'd16,   8'd16,   8'd0,    1'b1, 1'b0, 9);
        run("mul_ff_ff",2'b10, 3'b000, 8'hFF,   8'hFF,   8'h01,   1'b1, 1'b0, 9);
        run("mul_zero", 2'b10, 3'b000, 8'd0,    8'd77,   8'd0,    1'b0, 1'b0, 9);
        run("shl",      2'b10, 3'b001, 8'h81,   8'h03,   8'h08,   1'b0, 1'b0, 1);
        run("shl_bmask",2'b10, 3'b001, 8'h01,   8'h0B,   8'h08,   1'b0, 1'b0, 1);
        run("shr",      2'b10, 3'b010, 8'h80,   8'd7,    8'h01,   1'b0, 1'b0, 1);
        run("rol",      2'b10, 3'b011, 8'h81,   8'd1,    8'h03,   1'b0, 1'b0, 1);
        run("rol_0",    2'b10, 3'b011, 8'hC3,   8'd0,    8'hC3,   1'b0, 1'b0, 1);
        run("rsv_m10",  2'b10, 3'b100, 8'd9,    8'd9,    8'd0,    1'b0, 1'b1, 1);
        run("rsv_m11",  2'b11, 3'b000, 8'd200,  8'd100,  8'd0,    1'b0, 1'b1, 1);
        run("ill_clr",  2'b00, 3'b000, 8'd1,    8'd2,    8'd3,    1'b0, 1'b0, 1);

        // Consumer stall in DONE, then take-and-accept in the same cycle
        @(negedge clk);
        out_ready = 1'b0;
        issue("stall_add", 2'b00, 3'b000, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'd2 ||
                overflow !== 1'b0 || zero !== 1'b0 || illegal !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold ov/ir/res/ovf/z got %0b/%0b/%0d/%0b/%0b need 1/0/2/0/0",
                         out_valid, in_ready, result, overflow, zero);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        issue("b2b_and", 2'b01, 3'b000, 8'hFF, 8'h0F, 8'h0F, 1'b0, 1'b0, 1);
        drain("b2b_and");

        run("pre_rst", 2'b00, 3'b000, 8'd2, 8'd3, 8'd5, 1'b0, 1'b0, 1);

        // Reset during the 4th MUL cycle aborts the op without output
        @(negedge clk);
        mode = 2'b10; op = 3'b000; a = 8'd15; b = 8'd17; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 8'd0 || zero !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_mul_rst ov/ir/res/z got %0b/%0b/%0d/%0b need 0/1/0/1",
                     out_valid, in_ready, result, zero);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_bad++;
            $display("FAIL post_rst_stale out_valid_seen=1 need 0");
        end
        run("post_rst", 2'b00, 3'b000, 8'd7, 8'd8, 8'd15, 1'b0, 1'b0, 1);

        // W=16 wraparound
        @(negedge clk);
        w_mode = 2'b00; w_op = 3'b000; w_a = 16'hFFFF; w_b = 16'h0001; w_in_valid = 1'b1;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        n = 0;
        while (!w_out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (w_out_valid !== 1'b1 || w_result !== 16'h0000 || w_overflow !== 1'b1 ||
            w_zero !== 1'b1 || w_illegal !== 1'b0 || n != 0) begin
            n_bad++;
            $display("FAIL w16_add ov/res/ovf/z/ill/wait got %0b/%0h/%0b/%0b/%0b/%0d need 1/0/1/1/0/0",
                     w_out_valid, w_result, w_overflow, w_zero, w_illegal, n);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
